// File: rtl/rivyera_reg_responder_if.sv
// Command/response bus between the RIVYERA API register ports and the register responder.
// slave: responder side; master: API port side (FIFO head in, response out).
interface rivyera_reg_responder_if;
    localparam int unsigned C_LENGTH_SLOT = 4;
    localparam int unsigned C_LENGTH_FPGA = 4;
    localparam int unsigned C_LENGTH_REG  = 8;
    localparam int unsigned C_LENGTH_CMD  = 8;
    localparam int unsigned C_LENGTH_DATA = 64;

    logic [C_LENGTH_SLOT-1:0] api_i_src_slot_in;
    logic [C_LENGTH_FPGA-1:0] api_i_src_fpga_in;
    logic [C_LENGTH_REG-1:0]  api_i_src_reg_in;
    logic [C_LENGTH_CMD-1:0]  api_i_src_cmd_in;
    logic [C_LENGTH_REG-1:0]  api_i_tgt_reg_in;
    logic [C_LENGTH_CMD-1:0]  api_i_tgt_cmd_in;
    logic [C_LENGTH_DATA-1:0] api_i_data_in;
    logic                     api_i_empty_in;
    logic                     api_i_rd_en_out;

    logic                     api_o_rfd_in;
    logic [C_LENGTH_SLOT-1:0] api_o_tgt_slot_out;
    logic [C_LENGTH_FPGA-1:0] api_o_tgt_fpga_out;
    logic [C_LENGTH_REG-1:0]  api_o_tgt_reg_out;
    logic [C_LENGTH_CMD-1:0]  api_o_tgt_cmd_out;
    logic [C_LENGTH_REG-1:0]  api_o_src_reg_out;
    logic [C_LENGTH_CMD-1:0]  api_o_src_cmd_out;
    logic [C_LENGTH_DATA-1:0] api_o_data_out;
    logic                     api_o_wr_en_out;

    modport slave (
        input  api_i_src_slot_in, api_i_src_fpga_in, api_i_src_reg_in, api_i_src_cmd_in,
        input  api_i_tgt_reg_in, api_i_tgt_cmd_in, api_i_data_in, api_i_empty_in,
        output api_i_rd_en_out,
        input  api_o_rfd_in,
        output api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out, api_o_tgt_cmd_out,
        output api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out, api_o_wr_en_out
    );

    modport master (
        output api_i_src_slot_in, api_i_src_fpga_in, api_i_src_reg_in, api_i_src_cmd_in,
        output api_i_tgt_reg_in, api_i_tgt_cmd_in, api_i_data_in, api_i_empty_in,
        input  api_i_rd_en_out,
        output api_o_rfd_in,
        input  api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out, api_o_tgt_cmd_out,
        input  api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out, api_o_wr_en_out
    );
endinterface

// File: rtl/rivyera_reg_responder.sv
// Register-file command responder: pops CMD_WR/CMD_RD words, stores writes, answers reads.
// Optional macro RIVYERA_REG_WR_ACK_EN: every CMD_WR also produces an acknowledge response.
module rivyera_reg_responder #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                    api_clk_in,
    input  logic                    api_rst_in,
    rivyera_reg_responder_if.slave  bus,
    output logic                    busy_out
);
    localparam int unsigned C_LENGTH_SLOT = 4;
    localparam int unsigned C_LENGTH_FPGA = 4;
    localparam int unsigned C_LENGTH_REG  = 8;
    localparam int unsigned C_LENGTH_CMD  = 8;
    localparam int unsigned C_LENGTH_DATA = 64;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [C_LENGTH_CMD-1:0] CMD_WR   = C_LENGTH_CMD'(1);
    localparam logic [C_LENGTH_CMD-1:0] CMD_RD   = C_LENGTH_CMD'(2);
    localparam logic [C_LENGTH_REG-1:0] CNT_ADDR = C_LENGTH_REG'(NUM_REGS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state, state_nxt;

    logic [C_LENGTH_SLOT-1:0] lat_src_slot;
    logic [C_LENGTH_FPGA-1:0] lat_src_fpga;
    logic [C_LENGTH_REG-1:0]  lat_src_reg;
    logic [C_LENGTH_CMD-1:0]  lat_src_cmd;
    logic [C_LENGTH_REG-1:0]  lat_tgt_reg;
    logic [C_LENGTH_CMD-1:0]  lat_tgt_cmd;
    logic [C_LENGTH_DATA-1:0] lat_data;

    logic [C_LENGTH_DATA-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_inc;

    logic [C_LENGTH_SLOT-1:0] resp_tgt_slot;
    logic [C_LENGTH_FPGA-1:0] resp_tgt_fpga;
    logic [C_LENGTH_REG-1:0]  resp_tgt_reg;
    logic [C_LENGTH_CMD-1:0]  resp_tgt_cmd;
    logic [C_LENGTH_REG-1:0]  resp_src_reg;
    logic [C_LENGTH_CMD-1:0]  resp_src_cmd;
    logic [C_LENGTH_DATA-1:0] resp_data;
    logic [C_LENGTH_DATA-1:0] resp_data_nxt;

    logic             pop;
    logic             in_range;
    logic             is_wr;
    logic             is_rd;
    logic             resp_go;
    logic [IDX_W-1:0] idx;

    assign in_range = lat_tgt_reg < CNT_ADDR;
    assign is_wr    = lat_tgt_cmd == CMD_WR;
    assign is_rd    = lat_tgt_cmd == CMD_RD;
    assign idx      = IDX_W'(lat_tgt_reg);
    assign cnt_inc  = cnt + CNT_W'(1);

`ifdef RIVYERA_REG_WR_ACK_EN
    assign resp_go = is_rd | is_wr;
`else
    assign resp_go = is_rd;
`endif

    // State register
    always_ff @(posedge api_clk_in or negedge api_rst_in) begin
        if (!api_rst_in) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next state and handshake outputs; gated by reset so they drop without a clock
    always_comb begin
        state_nxt           = state;
        pop                 = 1'b0;
        bus.api_i_rd_en_out = 1'b0;
        bus.api_o_wr_en_out = 1'b0;
        busy_out            = 1'b0;
        case (state)
            IDLE: begin
                pop = api_rst_in & ~bus.api_i_empty_in;
                if (!bus.api_i_empty_in) state_nxt = EXEC;
            end
            EXEC: begin
                busy_out  = 1'b1;
                state_nxt = resp_go ? RESP : IDLE;
            end
            RESP: begin
                busy_out            = 1'b1;
                bus.api_o_wr_en_out = bus.api_o_rfd_in;
                if (bus.api_o_rfd_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.api_i_rd_en_out = pop;
    end

    // Capture the head-of-FIFO word as it is popped
    always_ff @(posedge api_clk_in or negedge api_rst_in) begin
        if (!api_rst_in) begin
            lat_src_slot <= '0;
            lat_src_fpga <= '0;
            lat_src_reg  <= '0;
            lat_src_cmd  <= '0;
            lat_tgt_reg  <= '0;
            lat_tgt_cmd  <= '0;
            lat_data     <= '0;
        end else if (pop) begin
            lat_src_slot <= bus.api_i_src_slot_in;
            lat_src_fpga <= bus.api_i_src_fpga_in;
            lat_src_reg  <= bus.api_i_src_reg_in;
            lat_src_cmd  <= bus.api_i_src_cmd_in;
            lat_tgt_reg  <= bus.api_i_tgt_reg_in;
            lat_tgt_cmd  <= bus.api_i_tgt_cmd_in;
            lat_data     <= bus.api_i_data_in;
        end
    end

    // Register file and transaction counter, both updated in EXEC
    always_ff @(posedge api_clk_in or negedge api_rst_in) begin
        if (!api_rst_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
            cnt <= '0;
        end else if (state == EXEC) begin
            cnt <= cnt_inc;
            if (is_wr && in_range) regs[idx] <= lat_data;
        end
    end

    // Counter read returns the value including the current command
    always_comb begin
        resp_data_nxt = '0;
        if (is_wr) begin
            if (in_range) resp_data_nxt = lat_data;
        end else if (in_range) begin
            resp_data_nxt = regs[idx];
        end else if (lat_tgt_reg == CNT_ADDR) begin
            resp_data_nxt = C_LENGTH_DATA'(cnt_inc);
        end
    end

    // Response word: loaded in EXEC, held through RESP
    always_ff @(posedge api_clk_in or negedge api_rst_in) begin
        if (!api_rst_in) begin
            resp_tgt_slot <= '0;
            resp_tgt_fpga <= '0;
            resp_tgt_reg  <= '0;
            resp_tgt_cmd  <= CMD_WR;
            resp_src_reg  <= '0;
            resp_src_cmd  <= CMD_WR;
            resp_data     <= '0;
        end else if (state == EXEC && resp_go) begin
            resp_tgt_slot <= lat_src_slot;
            resp_tgt_fpga <= lat_src_fpga;
            resp_tgt_reg  <= lat_src_reg;
            resp_tgt_cmd  <= lat_src_cmd;
            resp_src_reg  <= lat_tgt_reg;
            resp_src_cmd  <= CMD_WR;
            resp_data     <= resp_data_nxt;
        end
    end

    assign bus.api_o_tgt_slot_out = resp_tgt_slot;
    assign bus.api_o_tgt_fpga_out = resp_tgt_fpga;
    assign bus.api_o_tgt_reg_out  = resp_tgt_reg;
    assign bus.api_o_tgt_cmd_out  = resp_tgt_cmd;
    assign bus.api_o_src_reg_out  = resp_src_reg;
    assign bus.api_o_src_cmd_out  = resp_src_cmd;
    assign bus.api_o_data_out     = resp_data;
endmodule

// File: tb/tb_rivyera_reg_responder.sv
// Self-checking bench for rivyera_reg_responder: vector table, corner sequences, random vs. model.
module tb_rivyera_reg_responder;
    localparam int unsigned NUM_REGS = 16;
    localparam logic [7:0]  CMD_WR   = 8'h01;
    localparam logic [7:0]  CMD_RD   = 8'h02;
    localparam logic [7:0]  CMD_NOP  = 8'h7F;
`ifdef RIVYERA_REG_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  slot;
        logic [3:0]  fpga;
        logic [7:0]  sreg;
        logic [7:0]  scmd;
        logic [7:0]  treg;
        logic [7:0]  tcmd;
        logic [63:0] data;
    } cmd_t;

    typedef struct {
        logic [3:0]  tslot;
        logic [3:0]  tfpga;
        logic [7:0]  treg;
        logic [7:0]  tcmd;
        logic [7:0]  sreg;
        logic [7:0]  scmd;
        logic [63:0] data;
    } rsp_t;

    typedef struct {
        cmd_t        c;
        bit          push;
        logic [63:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    rivyera_reg_responder_if bus ();

    rivyera_reg_responder #(.NUM_REGS(NUM_REGS)) dut (
        .api_clk_in (clk),
        .api_rst_in (rst_n),
        .bus        (bus.slave),
        .busy_out   (busy)
    );

    always #5 clk = ~clk;

    cmd_t        fifo_q [$];
    rsp_t        got_q  [$];
    rsp_t        exp_q  [$];
    vec_t        vq     [$];
    logic [63:0] m_regs [NUM_REGS];
    logic [31:0] m_cnt;
    bit          rfd;
    bit          last_rd;
    int          cyc, pop_cnt, last_pop_cyc, prev_pop_cyc, last_push_cyc;
    int          checks, errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [3:0] slot, input logic [3:0] fpga, input logic [7:0] sreg,
                                input logic [7:0] scmd, input logic [7:0] treg, input logic [7:0] tcmd,
                                input logic [63:0] data);
        cmd_t c;
        c.slot = slot; c.fpga = fpga; c.sreg = sreg; c.scmd = scmd;
        c.treg = treg; c.tcmd = tcmd; c.data = data;
        return c;
    endfunction

    // Response routing: swap source and target, always answer as a write
    function automatic rsp_t route(input cmd_t c, input logic [63:0] d);
        rsp_t r;
        r.tslot = c.slot; r.tfpga = c.fpga; r.treg = c.sreg; r.tcmd = c.scmd;
        r.sreg = c.treg;  r.scmd = CMD_WR;  r.data = d;
        return r;
    endfunction

    function automatic logic [63:0] hdr(input rsp_t r);
        return 64'({r.tslot, r.tfpga, r.treg, r.tcmd, r.sreg, r.scmd});
    endfunction

    // Behavioural model: applies one command in FIFO order
    task automatic model(input cmd_t c);
        int a;
        a = int'(c.treg);
        m_cnt = m_cnt + 32'd1;
        if (c.tcmd == CMD_WR) begin
            if (a < int'(NUM_REGS)) m_regs[a] = c.data;
            if (ACK) exp_q.push_back(route(c, (a < int'(NUM_REGS)) ? c.data : 64'h0));
        end else if (c.tcmd == CMD_RD) begin
            if (a < int'(NUM_REGS))       exp_q.push_back(route(c, m_regs[a]));
            else if (a == int'(NUM_REGS)) exp_q.push_back(route(c, 64'(m_cnt)));
            else                          exp_q.push_back(route(c, 64'h0));
        end
    endtask

    // One clock: drive FIFO head and rfd after the falling edge, sample shortly after
    task automatic tick();
        cmd_t h;
        rsp_t r;
        @(negedge clk);
        bus.api_o_rfd_in   = rfd;
        bus.api_i_empty_in = (fifo_q.size() == 0);
        if (fifo_q.size() > 0) begin
            h = fifo_q[0];
            bus.api_i_src_slot_in = h.slot;
            bus.api_i_src_fpga_in = h.fpga;
            bus.api_i_src_reg_in  = h.sreg;
            bus.api_i_src_cmd_in  = h.scmd;
            bus.api_i_tgt_reg_in  = h.treg;
            bus.api_i_tgt_cmd_in  = h.tcmd;
            bus.api_i_data_in     = h.data;
        end
        #1;
        check("rd_en_while_empty", 64'(bus.api_i_rd_en_out & bus.api_i_empty_in), 64'h0);
        check("wr_en_without_rfd", 64'(bus.api_o_wr_en_out & ~rfd), 64'h0);
        last_rd = bus.api_i_rd_en_out;
        if (bus.api_i_rd_en_out && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
        end
        if (bus.api_o_wr_en_out) begin
            r.tslot = bus.api_o_tgt_slot_out; r.tfpga = bus.api_o_tgt_fpga_out;
            r.treg  = bus.api_o_tgt_reg_out;  r.tcmd  = bus.api_o_tgt_cmd_out;
            r.sreg  = bus.api_o_src_reg_out;  r.scmd  = bus.api_o_src_cmd_out;
            r.data  = bus.api_o_data_out;
            got_q.push_back(r);
            last_push_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run_idle(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (fifo_q.size() == 0) && !busy && !last_rd;
        end
        check("drain_in_budget", 64'(done), 64'h1);
    endtask

    task automatic do_reset();
        tick();
        #1 rst_n = 1'b0;
        fifo_q.delete();
        repeat (3) tick();
        #1 rst_n = 1'b1;
    endtask

    // Single command with rfd=1; checks push count and the pushed word
    task automatic txn(input string name, input cmd_t c, input bit p, input logic [63:0] d);
        int   gc;
        rsp_t e;
        gc = got_q.size();
        fifo_q.push_back(c);
        run_idle(50);
        check({name, "_push"}, 64'(got_q.size() - gc), 64'(p));
        if (p && got_q.size() > gc) begin
            e = route(c, d);
            check({name, "_route"}, hdr(got_q[gc]), hdr(e));
            check({name, "_data"}, got_q[gc].data, d);
        end
    endtask

    initial begin
        int          gc, pc, push_c;
        cmd_t        c;
        logic [63:0] v5;
        checks = 0; errors = 0; cyc = 0; pop_cnt = 0;
        last_pop_cyc = 0; prev_pop_cyc = 0; last_push_cyc = 0; last_rd = 1'b0;
        rfd = 1'b1;
        rst_n = 1'b0;
        bus.api_i_empty_in = 1'b1;
        bus.api_o_rfd_in   = 1'b1;
        bus.api_i_src_slot_in = '0; bus.api_i_src_fpga_in = '0; bus.api_i_src_reg_in = '0;
        bus.api_i_src_cmd_in  = '0; bus.api_i_tgt_reg_in  = '0; bus.api_i_tgt_cmd_in = '0;
        bus.api_i_data_in     = '0;
        v5 = 64'h0123_4567_89AB_CDEF;

        add_vectors();

        tick();
        check("rst_busy",     64'(busy), 64'h0);
        check("rst_wr_en",    64'(bus.api_o_wr_en_out), 64'h0);
        check("rst_tgt_cmd",  64'(bus.api_o_tgt_cmd_out), 64'(CMD_WR));
        check("rst_src_cmd",  64'(bus.api_o_src_cmd_out), 64'(CMD_WR));
        check("rst_data",     bus.api_o_data_out, 64'h0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            txn($sformatf("vec%0d", i), vq[i].c, vq[i].push, vq[i].data);

        // Back-to-back write then read of reg 0
        gc = got_q.size(); pc = pop_cnt;
        fifo_q.push_back(mk(4'h3, 4'h2, 8'h11, 8'h05, 8'd0, CMD_WR, 64'hCAFE_F00D_1234_5678));
        fifo_q.push_back(mk(4'h3, 4'h2, 8'h12, 8'h05, 8'd0, CMD_RD, 64'h0));
        run_idle(50);
        check("b2b_pops",   64'(pop_cnt - pc), 64'h2);
        check("b2b_pushes", 64'(got_q.size() - gc), 64'(ACK ? 2 : 1));
        check("b2b_gap",    64'(last_pop_cyc - prev_pop_cyc), 64'(ACK ? 3 : 2));
        if (got_q.size() > gc) check("b2b_rd_data", got_q[got_q.size()-1].data, 64'hCAFE_F00D_1234_5678);

        // Back-pressure: read stalled in RESP for 10+ cycles, next command waiting
        gc = got_q.size(); pc = pop_cnt;
        rfd = 1'b0;
        fifo_q.push_back(mk(4'h1, 4'h1, 8'h21, 8'h03, 8'd5, CMD_RD, 64'h0));
        fifo_q.push_back(mk(4'h1, 4'h1, 8'h22, 8'h03, 8'd0, CMD_RD, 64'h0));
        repeat (12) tick();
        check("stall_pops",   64'(pop_cnt - pc), 64'h1);
        check("stall_pushes", 64'(got_q.size() - gc), 64'h0);
        check("stall_busy",   64'(busy), 64'h1);
        check("stall_hold",   bus.api_o_data_out, v5);
        rfd = 1'b1;
        tick();
        check("release_push", 64'(got_q.size() - gc), 64'h1);
        push_c = last_push_cyc;
        tick();
        check("pop_after_push", 64'(last_pop_cyc - push_c), 64'h1);
        run_idle(50);
        check("bp_total_pushes", 64'(got_q.size() - gc), 64'h2);
        if (got_q.size() >= gc + 2) begin
            check("bp_rd5",  got_q[gc].data, v5);
            check("bp_rd0",  got_q[gc+1].data, 64'hCAFE_F00D_1234_5678);
        end

        // Reset while a response is pending and the FIFO still holds a word
        gc = got_q.size();
        rfd = 1'b0;
        fifo_q.push_back(mk(4'h2, 4'h0, 8'h31, 8'h03, 8'd5, CMD_RD, 64'h0));
        fifo_q.push_back(mk(4'h2, 4'h0, 8'h32, 8'h03, 8'd3, CMD_RD, 64'h0));
        repeat (5) tick();
        rfd = 1'b1;
        bus.api_o_rfd_in = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_rd_en", 64'(bus.api_i_rd_en_out), 64'h0);
        check("rstmid_wr_en", 64'(bus.api_o_wr_en_out), 64'h0);
        check("rstmid_busy",  64'(busy), 64'h0);
        check("rstmid_data",  bus.api_o_data_out, 64'h0);
        fifo_q.delete();
        repeat (3) tick();
        #1 rst_n = 1'b1;
        run_idle(20);
        check("rstmid_dropped", 64'(got_q.size() - gc), 64'h0);
        txn("post_rst_rd3",  mk(4'h1, 4'h0, 8'h01, 8'h02, 8'd3,  CMD_RD, 64'h0), 1'b1, 64'h0);
        txn("post_rst_rd5",  mk(4'h1, 4'h0, 8'h02, 8'h02, 8'd5,  CMD_RD, 64'h0), 1'b1, 64'h0);
        txn("post_rst_cnt",  mk(4'h1, 4'h0, 8'h03, 8'h02, 8'd16, CMD_RD, 64'h0), 1'b1, 64'h3);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = 64'h0;
        m_cnt = 32'h0;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                c.slot = 4'($urandom); c.fpga = 4'($urandom);
                c.sreg = 8'($urandom); c.scmd = 8'($urandom);
                c.data = {$urandom, $urandom};
                c.treg = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
                case ($urandom_range(0, 9))
                    0:       c.tcmd = 8'($urandom_range(3, 255));
                    1, 2, 3, 4: c.tcmd = CMD_WR;
                    default: c.tcmd = CMD_RD;
                endcase
                fifo_q.push_back(c);
                model(c);
            end
            rfd = ($urandom_range(0, 3) != 0);
            tick();
        end
        rfd = 1'b1;
        run_idle(5000);
        check("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("rand%0d_route", i), hdr(got_q[i]), hdr(exp_q[i]));
            check($sformatf("rand%0d_data", i), got_q[i].data, exp_q[i].data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic add_vec(input cmd_t c, input bit p, input logic [63:0] d);
        vec_t v;
        v.c = c; v.push = p; v.data = d;
        vq.push_back(v);
    endtask

    // Expected data derived by hand; counter starts at 0 after the first reset
    task automatic add_vectors();
        add_vec(mk(4'h1, 4'h0, 8'h09, 8'h02, 8'd3,   CMD_RD,  64'h0), 1'b1, 64'h0);
        add_vec(mk(4'h2, 4'h1, 8'h07, 8'h01, 8'd5,   CMD_WR,  64'h0123_4567_89AB_CDEF), ACK, 64'h0123_4567_89AB_CDEF);
        add_vec(mk(4'h2, 4'h1, 8'h07, 8'h01, 8'd5,   CMD_RD,  64'h0), 1'b1, 64'h0123_4567_89AB_CDEF);
        add_vec(mk(4'h5, 4'h3, 8'h40, 8'h09, 8'd16,  CMD_RD,  64'h0), 1'b1, 64'h4);
        add_vec(mk(4'h5, 4'h3, 8'h41, 8'h09, 8'd200, CMD_RD,  64'h0), 1'b1, 64'h0);
        add_vec(mk(4'h6, 4'h2, 8'h42, 8'h0A, 8'd16,  CMD_WR,  64'hDEAD), ACK, 64'h0);
        add_vec(mk(4'h6, 4'h2, 8'h43, 8'h0A, 8'd16,  CMD_RD,  64'h0), 1'b1, 64'h7);
        add_vec(mk(4'h7, 4'hF, 8'h44, 8'h0B, 8'd5,   CMD_NOP, 64'h5555), 1'b0, 64'h0);
        add_vec(mk(4'h7, 4'hF, 8'h45, 8'h0B, 8'd5,   CMD_RD,  64'h0), 1'b1, 64'h0123_4567_89AB_CDEF);
        add_vec(mk(4'h8, 4'h4, 8'h46, 8'h0C, 8'd15,  CMD_WR,  64'hFFFF_FFFF_FFFF_FFFF), ACK, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(mk(4'h8, 4'h4, 8'h47, 8'h0C, 8'd15,  CMD_RD,  64'h0), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(mk(4'h9, 4'h5, 8'h48, 8'h0D, 8'd16,  CMD_RD,  64'h0), 1'b1, 64'hC);
        add_vec(mk(4'h9, 4'h5, 8'h49, 8'h0D, 8'd200, CMD_WR,  64'h77), ACK, 64'h0);
        add_vec(mk(4'hA, 4'h6, 8'h4A, 8'h0E, 8'd16,  CMD_RD,  64'h0), 1'b1, 64'hE);
        add_vec(mk(4'hB, 4'h7, 8'h4B, 8'h0F, 8'd1,   CMD_WR,  64'hAA), ACK, 64'hAA);
    endtask
endmodule
